// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
//
// Types and constants shared by the pipeline stages of the ARM-subset core.
// It is imported by exe_mem_stage and status_reg. The id_exe and mem_wb
// stages use it too.
//
//   N_IDX/Z_IDX/C_IDX/V_IDX : bit positions of the flags inside an nzcv_t
//   nzcv_t                  : 4-bit {N,Z,C,V} status word
//   reg_addr_t              : architectural register index
//   mem_ctrl_t              : memory/writeback control bundle
// ---------------------------------------------------------------------------
package arm_pkg;

    localparam int unsigned N_IDX = 3;
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned C_IDX = 1;
    localparam int unsigned V_IDX = 0;

    localparam int unsigned REG_ADDR_W_DEF = 4;

    typedef logic [3:0]                nzcv_t;
    typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } mem_ctrl_t;

endpackage

// File: rtl/exe_mem_stage_status_reg.sv
// ---------------------------------------------------------------------------
// status_reg
//
// This is the architectural NZCV register. It loads d on a rising edge when en
// is high and clears on a synchronous reset. The ID-stage model reuses it.
//
// Optional feature (macro EXE_STATUS_BYPASS_EN): this adds the fwd output.
// fwd shows the value the register is about to take, so a conditional
// instruction can follow a flag-setting one with no stall.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   en   in   write enable
//   d    in   new {N,Z,C,V}
//   q    out  registered {N,Z,C,V}
//   fwd  out  (EXE_STATUS_BYPASS_EN only) en ? d : q
// ---------------------------------------------------------------------------
module status_reg
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] d,
`ifdef EXE_STATUS_BYPASS_EN
    output logic [3:0] fwd,
`endif
    output logic [3:0] q
);

    nzcv_t status_q;
    nzcv_t status_d;

    always_comb begin
        status_d = status_q;
        if (en) begin
            status_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign q = status_q;

`ifdef EXE_STATUS_BYPASS_EN
    assign fwd = en ? d : status_q;
`endif

endmodule

// File: rtl/exe_mem_stage.sv
// ---------------------------------------------------------------------------
// exe_mem_stage
//
// This is the EXE/MEM pipeline register of the 5-stage ARM-subset pipeline.
// It captures the ALU result, the store data, the destination register and the
// memory/writeback control. It owns the NZCV status register and counts the
// instructions that retire into MEM.
//
// Edge priority: rst > freeze > flush > load.
//
// Optional feature (macro EXE_STATUS_BYPASS_EN): this adds the status_fwd
// output, which bypasses the status value being written into the register.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   freeze               hold every piece of state
//   flush                squash the instruction entering this cycle
//   in_valid             EXE instruction valid
//   in_wb_en/in_mem_r_en/in_mem_w_en   control from EXE
//   in_s                 S bit (update NZCV)
//   in_alu_res           ALU result
//   in_alu_status        ALU {N,Z,C,V}
//   in_st_val            store data
//   in_dest              destination register
//   out_valid, out_wb_en, out_mem_r_en, out_mem_w_en   registered control
//   out_alu_res, out_st_val, out_dest                  registered data
//   status               NZCV (status[1] = C is the ALU carry-in)
//   status_fwd           (EXE_STATUS_BYPASS_EN only) bypassed NZCV
//   retired_cnt          wrapping retired-instruction counter
// ---------------------------------------------------------------------------
module exe_mem_stage
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic                  in_mem_w_en,
    input  logic                  in_s,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [3:0]            in_alu_status,
    input  logic [DATA_W-1:0]     in_st_val,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  out_valid,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic                  out_mem_w_en,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic [DATA_W-1:0]     out_st_val,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [3:0]            status,
`ifdef EXE_STATUS_BYPASS_EN
    output logic [3:0]            status_fwd,
`endif
    output logic [CNT_W-1:0]      retired_cnt
);

    logic                  load;
    logic                  status_we;

    logic                  valid_q,  valid_d;
    mem_ctrl_t             ctrl_q,   ctrl_d;
    logic [DATA_W-1:0]     res_q,    res_d;
    logic [DATA_W-1:0]     st_q,     st_d;
    logic [REG_ADDR_W-1:0] dest_q,   dest_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    // An instruction reaches MEM only on an edge that is neither frozen nor flushed.
    assign load      = ~freeze & ~flush;
    assign status_we = load & in_valid & in_s;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        st_d    = st_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            // Data fields load on both the flush and the load paths. Their value is
            // don't-care once out_valid is low, and loading them avoids a mux.
            res_d  = in_alu_res;
            st_d   = in_st_val;
            dest_d = in_dest;
            if (flush) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else begin
                valid_d         = in_valid;
                ctrl_d.wb_en    = in_wb_en    & in_valid;
                ctrl_d.mem_r_en = in_mem_r_en & in_valid;
                ctrl_d.mem_w_en = in_mem_w_en & in_valid;
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            res_q   <= '0;
            st_q    <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            st_q    <= st_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

    status_reg u_status_reg (
        .clk (clk),
        .rst (rst),
        .en  (status_we),
        .d   (in_alu_status),
`ifdef EXE_STATUS_BYPASS_EN
        .fwd (status_fwd),
`endif
        .q   (status)
    );

    assign out_valid    = valid_q;
    assign out_wb_en    = ctrl_q.wb_en;
    assign out_mem_r_en = ctrl_q.mem_r_en;
    assign out_mem_w_en = ctrl_q.mem_w_en;
    assign out_alu_res  = res_q;
    assign out_st_val   = st_q;
    assign out_dest     = dest_q;
    assign retired_cnt  = cnt_q;

    // A load and a store cannot be requested together.
    a_no_rw_conflict: assert property (@(posedge clk) disable iff (rst)
        !(in_mem_r_en && in_mem_w_en));

endmodule
